// File: rtl/cordic_scheduler_if.sv
// Requester-side bundle of the CORDIC scheduler. It carries the packed per-requester
// operands and the shared result bus, whose owner is marked by a one-hot strobe.
interface cordic_scheduler_if #(
  parameter int W = 16,
  parameter int V = 16,
  parameter int S = 2
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_degree;
  logic [2*W-1:0] req_x;
  logic [2*W-1:0] req_y;
  logic [2*S-1:0] req_sector;
  logic [1:0]     req_arctan_en;
  logic [1:0]     res_valid;
  logic [V-1:0]   res_degree;
  logic [V-1:0]   res_x;
  logic [V-1:0]   res_y;

  modport master (
    output req_valid, req_degree, req_x, req_y, req_sector, req_arctan_en,
    input  req_ready, res_valid, res_degree, res_x, res_y
  );

  modport slave (
    input  req_valid, req_degree, req_x, req_y, req_sector, req_arctan_en,
    output req_ready, res_valid, res_degree, res_x, res_y
  );
endinterface

// File: rtl/cordic_scheduler.sv
// Two-requester round-robin front end for a fixed-latency CORDIC pipeline. A tag
// shift register routes each result back to its owner, and flush drains in-flight work.
module cordic_scheduler #(
  parameter int UNSIGNED_INPUT_WIDTH  = 16,
  parameter int UNSIGNED_OUTPUT_WIDTH = 16,
  parameter int SECTOR_FLAG_WIDTH     = 2,
  parameter int PIPE_LATENCY          = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  cordic_scheduler_if.slave                req_if,
  output logic                             p_valid_in_o,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  p_degree_in_o,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  p_x_in_o,
  output logic [UNSIGNED_INPUT_WIDTH-1:0]  p_y_in_o,
  output logic [SECTOR_FLAG_WIDTH-1:0]     p_sector_in_o,
  output logic                             p_arctan_en_in_o,
  input  logic                             p_valid_out_i,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] p_degree_out_i,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] p_x_out_i,
  input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] p_y_out_i,
  input  logic                             flush_req_i,
  output logic                             flush_done_o,
  output logic                             tag_err_o
);
  localparam int W  = UNSIGNED_INPUT_WIDTH;
  localparam int V  = UNSIGNED_OUTPUT_WIDTH;
  localparam int S  = SECTOR_FLAG_WIDTH;
  localparam int L  = PIPE_LATENCY;
  localparam int CW = $clog2(PIPE_LATENCY + 2);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           flush_block_q, flush_block_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [L-1:0]   tag_v_q, tag_o_q;
  logic           p_valid_q, p_owner_q, p_arctan_q;
  logic [W-1:0]   p_degree_q, p_x_q, p_y_q;
  logic [S-1:0]   p_sector_q;
  logic [1:0]     res_valid_q;
  logic [V-1:0]   res_degree_q, res_x_q, res_y_q;
  logic           tag_err_q;

  logic           issue_en, xfer, owner, accept, mismatch;
  logic [1:0]     grant;
  logic [W-1:0]   sel_degree, sel_x, sel_y;
  logic [S-1:0]   sel_sector;
  logic           sel_arctan;

  assign owner    = grant[1];
  assign xfer     = |grant;
  assign accept   = p_valid_out_i & tag_v_q[L-1];
  assign mismatch = p_valid_out_i ^ tag_v_q[L-1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    issue_en      = 1'b0;
    flush_block_d = (state_q == DONE) ? flush_req_i : (flush_block_q & flush_req_i);
    unique case (state_q)
      RUN:     if (flush_req_i && !flush_block_q) state_d = DRAIN;
               else                               issue_en = rst;
      DRAIN:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Round robin: with both requesters valid, prio_q names the one that was not granted last.
  always_comb begin
    grant = 2'b00;
    if (issue_en) begin
      unique case (req_if.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    prio_d     = xfer ? ~owner : prio_q;
    sel_degree = owner ? req_if.req_degree[W +: W] : req_if.req_degree[0 +: W];
    sel_x      = owner ? req_if.req_x[W +: W]      : req_if.req_x[0 +: W];
    sel_y      = owner ? req_if.req_y[W +: W]      : req_if.req_y[0 +: W];
    sel_sector = owner ? req_if.req_sector[S +: S] : req_if.req_sector[0 +: S];
    sel_arctan = owner ? req_if.req_arctan_en[1]   : req_if.req_arctan_en[0];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !accept && cnt_q != '1)      cnt_d = cnt_q + 1'b1;
    else if (!xfer && accept && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: the tag shift register is reset along with everything else, so a stray
  // p_valid_out after reset is reported as an error instead of being routed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      prio_q        <= 1'b0;
      flush_block_q <= 1'b0;
      cnt_q         <= '0;
      tag_v_q       <= '0;
      tag_o_q       <= '0;
      p_valid_q     <= 1'b0;
      p_owner_q     <= 1'b0;
      p_degree_q    <= '0;
      p_x_q         <= '0;
      p_y_q         <= '0;
      p_sector_q    <= '0;
      p_arctan_q    <= 1'b0;
      res_valid_q   <= 2'b00;
      res_degree_q  <= '0;
      res_x_q       <= '0;
      res_y_q       <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      flush_block_q <= flush_block_d;
      cnt_q         <= cnt_d;
      tag_v_q       <= {tag_v_q[L-2:0], p_valid_q};
      tag_o_q       <= {tag_o_q[L-2:0], p_owner_q};
      p_valid_q     <= xfer;
      if (xfer) begin
        p_owner_q  <= owner;
        p_degree_q <= sel_degree;
        p_x_q      <= sel_x;
        p_y_q      <= sel_y;
        p_sector_q <= sel_sector;
        p_arctan_q <= sel_arctan;
      end
      res_valid_q <= accept ? (tag_o_q[L-1] ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        res_degree_q <= p_degree_out_i;
        res_x_q      <= p_x_out_i;
        res_y_q      <= p_y_out_i;
      end
      tag_err_q <= tag_err_q | mismatch;
    end
  end

  assign req_if.req_ready  = grant;
  assign req_if.res_valid  = res_valid_q;
  assign req_if.res_degree = res_degree_q;
  assign req_if.res_x      = res_x_q;
  assign req_if.res_y      = res_y_q;
  assign p_valid_in_o      = p_valid_q;
  assign p_degree_in_o     = p_degree_q;
  assign p_x_in_o          = p_x_q;
  assign p_y_in_o          = p_y_q;
  assign p_sector_in_o     = p_sector_q;
  assign p_arctan_en_in_o  = p_arctan_q;
  assign flush_done_o      = (state_q == DONE);
  assign tag_err_o         = tag_err_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Scenario bench for cordic_scheduler: a behavioural fixed-latency pipeline sits behind
// the DUT, and each scenario queues its expected results and compares them with what arrives.
module tb_cordic_scheduler;
  localparam int W = 16, V = 16, S = 2, L = 8;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [1:0]   v;
    logic [V-1:0] d;
    logic [V-1:0] x;
    logic [V-1:0] y;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_scheduler_if #(.W(W), .V(V), .S(S)) rif ();

  logic         p_valid_in, p_arctan_en_in, p_valid_out;
  logic [W-1:0] p_degree_in, p_x_in, p_y_in;
  logic [S-1:0] p_sector_in;
  logic [V-1:0] p_degree_out, p_x_out, p_y_out;
  logic         flush_req = 1'b0;
  logic         flush_done, tag_err;
  logic         force_pv = 1'b0;

  cordic_scheduler #(
    .UNSIGNED_INPUT_WIDTH(W), .UNSIGNED_OUTPUT_WIDTH(V),
    .SECTOR_FLAG_WIDTH(S), .PIPE_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .req_if(rif.slave),
    .p_valid_in_o(p_valid_in), .p_degree_in_o(p_degree_in), .p_x_in_o(p_x_in),
    .p_y_in_o(p_y_in), .p_sector_in_o(p_sector_in), .p_arctan_en_in_o(p_arctan_en_in),
    .p_valid_out_i(p_valid_out), .p_degree_out_i(p_degree_out), .p_x_out_i(p_x_out),
    .p_y_out_i(p_y_out), .flush_req_i(flush_req), .flush_done_o(flush_done),
    .tag_err_o(tag_err)
  );

  // Behavioural pipeline: exactly L cycles, not reset, with a fixed transform.
  logic [L-1:0] pv = '0;
  logic [W-1:0] pd [L];
  logic [W-1:0] px [L];
  logic [W-1:0] py [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], p_valid_in === 1'b1};
    pd[0] <= p_degree_in;
    px[0] <= p_x_in;
    py[0] <= p_y_in;
    for (int i = 1; i < L; i++) begin
      pd[i] <= pd[i-1];
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign p_valid_out  = pv[L-1] | force_pv;
  assign p_degree_out = pd[L-1] ^ 16'h5A5A;
  assign p_x_out      = px[L-1] + 16'd3;
  assign p_y_out      = py[L-1] - 16'd7;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  res_t rq[$];
  res_t eq[$];
  int   fd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (|rif.res_valid)
        rq.push_back('{cyc: 32'(cyc), v: rif.res_valid, d: rif.res_degree, x: rif.res_x, y: rif.res_y});
      if (flush_done) fd_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] opd(int r, int k);
    return W'(32'h1000 * (r + 1) + 32'h0111 * k);
  endfunction
  function automatic logic [W-1:0] opx(int r, int k);
    return W'(32'h2345 + 32'h0100 * r + 32'h0017 * k);
  endfunction
  function automatic logic [W-1:0] opy(int r, int k);
    return W'(32'h0004 + 32'h0800 * r + 32'h0003 * k);
  endfunction
  function automatic logic [S-1:0] ops(int r, int k);
    return S'(r + k + 1);
  endfunction
  function automatic logic opa(int r, int k);
    return ((r + k) % 2) == 1;
  endfunction

  // Expected result of requester r's operand set k, transferred in cycle c.
  function automatic res_t exp_res(int r, int k, int c);
    res_t e;
    e.cyc = 32'(c + L + 2);
    e.v   = (r == 1) ? 2'b10 : 2'b01;
    e.d   = opd(r, k) ^ 16'h5A5A;
    e.x   = opx(r, k) + 16'd3;
    e.y   = opy(r, k) - 16'd7;
    return e;
  endfunction

  task automatic drive_ops(int k);
    for (int r = 0; r < 2; r++) begin
      rif.req_degree[r*W +: W]  = opd(r, k);
      rif.req_x[r*W +: W]       = opx(r, k);
      rif.req_y[r*W +: W]       = opy(r, k);
      rif.req_sector[r*S +: S]  = ops(r, k);
      rif.req_arctan_en[r]      = opa(r, k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rif.req_valid = 2'b00;
    flush_req = 1'b0;
    force_pv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rq.delete();
    eq.delete();
    fd_cyc.delete();
  endtask

  task automatic wait_res(int n, output logic ok);
    int b = 0;
    while (rq.size() < n && b < 60) begin
      @(posedge clk);
      b++;
    end
    repeat (4) @(posedge clk);
    #1 ok = (rq.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_ops(7);
    rif.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rif.req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", rif.req_ready); end
    checks++; if (p_valid_in !== 1'b0) begin failures++; $display("FAIL reset_p_valid got=%b exp=0", p_valid_in); end
    checks++; if ({p_degree_in, p_x_in, p_y_in, p_sector_in, p_arctan_en_in} !== '0) begin
      failures++; $display("FAIL reset_p_data got=%h/%h/%h/%h/%b exp=0", p_degree_in, p_x_in, p_y_in, p_sector_in, p_arctan_en_in); end
    checks++; if (rif.res_valid !== 2'b00) begin failures++; $display("FAIL reset_res_valid got=%b exp=00", rif.res_valid); end
    checks++; if ({rif.res_degree, rif.res_x, rif.res_y} !== '0) begin
      failures++; $display("FAIL reset_res_data got=%h/%h/%h exp=0", rif.res_degree, rif.res_x, rif.res_y); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
  endtask

  task automatic test_single();
    logic ok;
    res_t e, g;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_ops(k);
      rif.req_valid = 2'b01;
      #1;
      checks++; if (rif.req_ready !== 2'b01) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=01", k, rif.req_ready); end
      eq.push_back(exp_res(0, k, cyc));
      @(posedge clk);
      #1;
      if (k == 0) begin
        checks++; if (p_valid_in !== 1'b1) begin failures++; $display("FAIL single_issue_valid got=%b exp=1", p_valid_in); end
        checks++; if ({p_degree_in, p_x_in, p_y_in} !== {opd(0, 0), opx(0, 0), opy(0, 0)}) begin
          failures++; $display("FAIL single_issue_data got=%h/%h/%h exp=%h/%h/%h", p_degree_in, p_x_in, p_y_in, opd(0, 0), opx(0, 0), opy(0, 0)); end
        checks++; if ({p_sector_in, p_arctan_en_in} !== {ops(0, 0), opa(0, 0)}) begin
          failures++; $display("FAIL single_issue_mode got=%b/%b exp=%b/%b", p_sector_in, p_arctan_en_in, ops(0, 0), opa(0, 0)); end
      end
    end
    rif.req_valid = 2'b00;
    wait_res(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d results exp=3", rq.size()); end
    while (eq.size() > 0) begin
      e = eq.pop_front();
      checks++;
      if (rq.size() == 0) begin failures++; $display("FAIL single_result got=none exp=%h", e); end
      else begin
        g = rq.pop_front();
        if (g !== e) begin failures++; $display("FAIL single_result got=%h exp=%h", g, e); end
      end
    end
    checks++; if (rq.size() != 0) begin failures++; $display("FAIL single_extra got=%0d extra results exp=0", rq.size()); end
  endtask

  task automatic test_round_robin();
    logic ok;
    logic [1:0] want;
    res_t e, g;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_ops(k);
      rif.req_valid = 2'b11;
      #1;
      want = (k % 2 == 1) ? 2'b10 : 2'b01;
      checks++; if (rif.req_ready !== want) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, rif.req_ready, want); end
      eq.push_back(exp_res(k % 2, k, cyc));
      @(posedge clk);
      #1;
    end
    rif.req_valid = 2'b00;
    wait_res(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got=%0d results exp=4", rq.size()); end
    while (eq.size() > 0) begin
      e = eq.pop_front();
      checks++;
      if (rq.size() == 0) begin failures++; $display("FAIL rr_result got=none exp=%h", e); end
      else begin
        g = rq.pop_front();
        if (g !== e) begin failures++; $display("FAIL rr_result got=%h exp=%h", g, e); end
      end
    end
    checks++; if (rq.size() != 0) begin failures++; $display("FAIL rr_extra got=%0d extra results exp=0", rq.size()); end
  endtask

  task automatic test_flush();
    logic ok;
    int t5 = 0;
    res_t e, g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_ops(k);
      rif.req_valid = 2'b11;
      eq.push_back(exp_res(k % 2, k, cyc));
      t5 = cyc;
      @(posedge clk);
      #1;
    end
    flush_req = 1'b1;
    #1;
    checks++; if (rif.req_ready !== 2'b00) begin failures++; $display("FAIL flush_ready got=%b exp=00", rif.req_ready); end
    @(posedge clk);
    #1 rif.req_valid = 2'b00;
    wait_res(5, ok);
    repeat (6) @(posedge clk);
    #1 flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL flush_timeout got=%0d results exp=5", rq.size()); end
    checks++; if (fd_cyc.size() != 1) begin failures++; $display("FAIL flush_done_count got=%0d exp=1", fd_cyc.size()); end
    else begin
      checks++; if (fd_cyc[0] != t5 + L + 3) begin failures++; $display("FAIL flush_done_cycle got=%0d exp=%0d", fd_cyc[0], t5 + L + 3); end
    end
    while (eq.size() > 0) begin
      e = eq.pop_front();
      checks++;
      if (rq.size() == 0) begin failures++; $display("FAIL flush_result got=none exp=%h", e); end
      else begin
        g = rq.pop_front();
        if (g !== e) begin failures++; $display("FAIL flush_result got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_tag_err();
    do_reset();
    @(posedge clk);
    #1 force_pv = 1'b1;
    #1;
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL tag_err_early got=%b exp=0", tag_err); end
    @(posedge clk);
    #1 force_pv = 1'b0;
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL tag_err_set got=%b exp=1", tag_err); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL tag_err_sticky got=%b exp=1", tag_err); end
    checks++; if (rq.size() != 0) begin failures++; $display("FAIL tag_err_res_valid got=%0d results exp=0", rq.size()); end
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL tag_err_clear got=%b exp=0", tag_err); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_ops(k);
      rif.req_valid = 2'b01;
      @(posedge clk);
      #1;
    end
    rif.req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    rif.req_valid = 2'b11;
    @(posedge clk);
    #1;
    checks++; if (rif.req_ready !== 2'b00) begin failures++; $display("FAIL inflight_ready got=%b exp=00", rif.req_ready); end
    checks++; if ({p_valid_in, p_degree_in, p_x_in, p_y_in, p_sector_in, p_arctan_en_in} !== '0) begin
      failures++; $display("FAIL inflight_issue got=%b/%h/%h/%h exp=0", p_valid_in, p_degree_in, p_x_in, p_y_in); end
    checks++; if ({rif.res_valid, flush_done, tag_err} !== '0) begin
      failures++; $display("FAIL inflight_status got=%b/%b/%b exp=0", rif.res_valid, flush_done, tag_err); end
    rst = 1'b1;
    rif.req_valid = 2'b00;
    rq.delete();
    repeat (L + 6) @(posedge clk);
    #1;
    checks++; if (rq.size() != 0) begin failures++; $display("FAIL inflight_results got=%0d exp=0", rq.size()); end
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL inflight_stray_tag_err got=%b exp=1", tag_err); end
  endtask

  initial begin
    rif.req_valid = 2'b00;
    drive_ops(0);
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_tag_err();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 UNSIGNED_INPUT_WIDTH, 16, operand width (W) of degree/x/y requests.
REQ-002 UNSIGNED_OUTPUT_WIDTH, 16, result width (V) of degree/x/y.
REQ-003 SECTOR_FLAG_WIDTH, 2, sector flag width (S).
REQ-004 PIPE_LATENCY, 8, fixed cycles from p_valid_in to matching p_valid_out; legal range 2..32.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-008 req_ready  out  2  per-requester grant; transfer when valid[i] & ready[i].
REQ-009 req_degree  in  2*W  packed angles; requester i at [i*W +: W].
REQ-010 req_x  in  2*W  packed x operands.
REQ-011 req_y  in  2*W  packed y operands.
REQ-012 req_sector  in  2*S  packed sector flags.
REQ-013 req_arctan_en  in  2  per-requester mode, 1 = vectoring (arctan), 0 = rotation.
REQ-014 p_valid_in  out  1  issue strobe to CORDIC pipeline.
REQ-015 p_degree_in  out  W  issued angle.
REQ-016 p_x_in  out  W  issued x.
REQ-017 p_y_in  out  W  issued y.
REQ-018 p_sector_in  out  S  issued sector.
REQ-019 p_arctan_en_in  out  1  issued mode.
REQ-020 p_valid_out  in  1  pipeline result strobe.
REQ-021 p_degree_out  in  V  pipeline angle result.
REQ-022 p_x_out  in  V  pipeline x result.
REQ-023 p_y_out  in  V  pipeline y result.
REQ-024 res_valid  out  2  one-hot result strobe to owning requester.
REQ-025 res_degree  out  V  registered angle result (shared bus).
REQ-026 res_x  out  V  registered x result.
REQ-027 res_y  out  V  registered y result.
REQ-028 flush_req  in  1  level request to stop issuing and drain pipeline.
REQ-029 flush_done  out  1  one-cycle pulse when drain completes.
REQ-030 tag_err  out  1  sticky flag: p_valid_out disagrees with tag tracker.

Function
REQ-031 FSM states RUN, DRAIN, DONE; RUN->DRAIN when flush_req=1; DRAIN->DONE when in-flight count=0; DONE->RUN next cycle, flush_done=1 only in DONE.
REQ-032 In RUN, req_ready is one-hot or zero: grant the single valid requester; if both valid, grant the one not granted last (round-robin pointer, reset value favours requester 0); pointer updates only on a transfer.
REQ-033 req_ready is combinational from req_valid and pointer, and 0 in DRAIN and DONE.
REQ-034 A transfer registers the granted operands onto p_* with p_valid_in=1 the next cycle; otherwise p_valid_in=0 and p_* data hold last values; issue rate up to one per cycle.
REQ-035 A PIPE_LATENCY-deep tag shift register records {valid, owner} for each issue cycle, aligned so its output coincides with the expected p_valid_out.
REQ-036 When p_valid_out=1 and tag valid, register p_*_out into res_* and assert res_valid bit = tag owner the following cycle (total issue-to-result latency PIPE_LATENCY+2 from transfer).
REQ-037 Mismatch (p_valid_out != tag valid) sets tag_err until reset; the result is dropped, res_valid stays 0.
REQ-038 In-flight counter (width ceil(log2(PIPE_LATENCY+2))) increments on transfer, decrements when res_valid asserts, both same cycle = unchanged; never wraps.
REQ-039 flush_req held through DONE does not re-enter DRAIN until flush_req drops for at least one cycle.

Reset
REQ-040 While rst=0 at a clock edge: state=RUN, pointer=0, tags cleared, counter=0, req_ready=0, p_valid_in=0, p_* data=0, res_valid=0, res_*=0, flush_done=0, tag_err=0; in-flight operations are discarded and later stray p_valid_out sets tag_err.

Verification
REQ-041 Only req_valid=01 for 3 cycles -> three grants to requester 0, res_valid=01 on cycles PIPE_LATENCY+2..+4 after first transfer with matching x/y/degree.
REQ-042 req_valid=11 held 4 cycles after reset -> grant order 0,1,0,1; res_valid sequence 01,10,01,10.
REQ-043 Issue 5 ops then flush_req=1 -> req_ready=0 immediately, flush_done pulses exactly once, the cycle after the fifth result.
REQ-044 p_valid_out forced 1 with empty tags -> tag_err=1 next cycle, res_valid stays 00, tag_err held until rst=0.
REQ-045 rst=0 for one cycle with 3 ops in flight -> all outputs zero next cycle, no res_valid for those ops.
